// File: rtl/weight_bank_loader_pkg.sv
// Shared types and default dimensions for the writable weight bank loader.
// The defaults match the sizes used by the ROM-based convolution layers.
package weight_loader_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int ADDR_DEF  = 7;
  localparam int NUM_DEF   = 64;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } loader_state_t;

endpackage

// File: rtl/weight_bank_loader_if.sv
// Load-stream handshake, status flags and the wide read port of the weight
// bank loader. The master side feeds weights and reads; the slave is the loader.
interface weight_bank_loader_if
  import weight_loader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ADDR  = ADDR_DEF,
  parameter int NUM   = NUM_DEF
);

  logic                          start;
  logic [WIDTH-1:0]              in_data;
  logic                          in_valid;
  logic                          in_ready;
  logic                          busy;
  logic                          loaded;
  logic [ADDR-1:0]               address;
  logic [0:NUM-1][WIDTH-1:0]     rom_out;

  modport master (
    output start, in_data, in_valid, address,
    input  in_ready, busy, loaded, rom_out
  );

  modport slave (
    input  start, in_data, in_valid, address,
    output in_ready, busy, loaded, rom_out
  );

endinterface

// File: rtl/weight_bank_loader_bank.sv
// One weight bank: WIDTH x 2**ADDR distributed RAM with a synchronous write
// port and an asynchronous read port. Contents are deliberately not reset.
module weight_bank
  import weight_loader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ADDR  = ADDR_DEF
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [ADDR-1:0]  waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [ADDR-1:0]  raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [0:(2**ADDR)-1];

  // Write one word when this bank is selected; no reset so it maps to LUT RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/weight_bank_loader.sv
// Writable replacement for the per-layer weight ROMs. Streams weight words
// address-major into NUM banks and serves a combinational NUM-wide read port.
module weight_bank_loader
  import weight_loader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ADDR  = ADDR_DEF,
  parameter int NUM   = NUM_DEF,
  parameter int DEPTH = 2**ADDR
) (
  input  logic                 clk,
  input  logic                 rst,
  weight_bank_loader_if.slave  bus
);

  localparam int BANK_W = (NUM > 1) ? $clog2(NUM) : 1;

  loader_state_t     state_q, state_d;
  logic [BANK_W-1:0] bankCnt_q, bankCnt_d;
  logic [ADDR-1:0]   addrCnt_q, addrCnt_d;

  logic              accept;
  logic              lastBank;
  logic              lastAddr;
  logic [WIDTH-1:0]  bankData [NUM];

  assign accept   = bus.in_valid && bus.in_ready;
  assign lastBank = (bankCnt_q == BANK_W'(NUM - 1));
  assign lastAddr = (addrCnt_q == ADDR'(DEPTH - 1));

  // Status flags come straight from the state register, so in_ready never
  // depends on in_valid and reset forces all of them low at once.
  assign bus.in_ready = (state_q == LOAD);
  assign bus.busy     = (state_q == LOAD);
  assign bus.loaded   = (state_q == DONE);

  // Next state: start is only honoured outside LOAD; the final word ends the load.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = LOAD;
      LOAD:    if (accept && lastBank && lastAddr) state_d = DONE;
      DONE:    if (bus.start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Counters restart on every entry into LOAD; bank index wraps and carries
  // into the address so the stream fills one row across all banks at a time.
  always_comb begin
    bankCnt_d = bankCnt_q;
    addrCnt_d = addrCnt_q;
    if ((state_q != LOAD) && (state_d == LOAD)) begin
      bankCnt_d = '0;
      addrCnt_d = '0;
    end else if (accept) begin
      if (lastBank) begin
        bankCnt_d = '0;
        addrCnt_d = addrCnt_q + 1'b1;
      end else begin
        bankCnt_d = bankCnt_q + 1'b1;
      end
    end
  end

  // State and counter registers; a reset mid-load simply abandons the load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bankCnt_q <= '0;
      addrCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bankCnt_q <= bankCnt_d;
      addrCnt_q <= addrCnt_d;
    end
  end

  for (genvar k = 0; k < NUM; k++) begin : g_bank
    weight_bank #(
      .WIDTH (WIDTH),
      .ADDR  (ADDR)
    ) u_bank (
      .clk     (clk),
      .we_i    (accept && (bankCnt_q == BANK_W'(k))),
      .waddr_i (addrCnt_q),
      .wdata_i (bus.in_data),
      .raddr_i (bus.address),
      .rdata_o (bankData[k])
    );
  end

  // Fan the per-bank read data out onto the packed read bus.
  always_comb begin
    bus.rom_out = '0;
    for (int k = 0; k < NUM; k++) begin
      bus.rom_out[k] = bankData[k];
    end
  end

endmodule

// File: tb/tb_weight_bank_loader.sv
// Self-checking bench for weight_bank_loader at the default 16 x 128 x 64 size.
// A reference image of every bank is kept alongside the driven stream.
module tb_weight_bank_loader;

  localparam int WIDTH = 16;
  localparam int ADDR  = 7;
  localparam int NUM   = 64;
  localparam int DEPTH = 128;
  localparam int TOTAL = NUM * DEPTH;

  typedef struct {
    logic [ADDR-1:0]  addr;
    int               bank;
    logic [WIDTH-1:0] expected;
    string            name;
  } readVec_t;

  logic clk;
  logic rst;

  weight_bank_loader_if #(.WIDTH(WIDTH), .ADDR(ADDR), .NUM(NUM)) bus ();

  weight_bank_loader #(
    .WIDTH (WIDTH),
    .ADDR  (ADDR),
    .NUM   (NUM),
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int               errors;
  int               checks;
  logic [WIDTH-1:0] model [0:NUM-1][0:DEPTH-1];
  logic [WIDTH-1:0] expQ [$];
  readVec_t         vecs [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the value the bench expects.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive a read address and queue the value the addressed bank should return.
  task automatic applyStimulus(input logic [ADDR-1:0] addr, input logic [WIDTH-1:0] exp);
    bus.address = addr;
    expQ.push_back(exp);
  endtask

  // Pop the oldest queued expectation and compare it with one bank's output.
  task automatic checkRead(input int bank, input string name);
    logic [WIDTH-1:0] e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: scoreboard empty, got %0h", name, bus.rom_out[bank]);
    end else begin
      e = expQ.pop_front();
      checkOutput(name, 32'(bus.rom_out[bank]), 32'(e));
    end
  endtask

  // Walk every address and compare all banks against the reference image.
  task automatic checkImage(input string label);
    for (int a = 0; a < DEPTH; a++) begin
      for (int k = 0; k < NUM; k++) begin
        applyStimulus(ADDR'(a), model[k][a]);
      end
      #1;
      for (int k = 0; k < NUM; k++) begin
        checkRead(k, label);
      end
    end
  endtask

  // Run the read vector table through the scoreboard.
  task automatic checkVectors();
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].addr, vecs[v].expected);
      #1;
      checkRead(vecs[v].bank, vecs[v].name);
    end
  endtask

  // Start a load and stream nWords words base+i, optionally with idle gaps and
  // an extra start pulse alongside word startAt. Returns at a falling edge.
  task automatic loadStream(input logic [WIDTH-1:0] base, input bit gap,
                            input int nWords, input int startAt, input string label);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput({label, " ready after start"}, 32'(bus.in_ready), 32'd1);
    checkOutput({label, " busy after start"}, 32'(bus.busy), 32'd1);
    checkOutput({label, " loaded drops"}, 32'(bus.loaded), 32'd0);
    for (int i = 0; i < nWords; i++) begin
      if (gap && i > 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 16'hDEAD;
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = base + WIDTH'(i);
      bus.start    = (i == startAt);
      if (i == TOTAL - 1) begin
        checkOutput({label, " loaded before last word"}, 32'(bus.loaded), 32'd0);
        checkOutput({label, " ready before last word"}, 32'(bus.in_ready), 32'd1);
      end
      @(posedge clk);
      model[i % NUM][i / NUM] = base + WIDTH'(i);
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.in_valid = 1'b0;
    if (nWords == TOTAL) begin
      checkOutput({label, " loaded after last word"}, 32'(bus.loaded), 32'd1);
      checkOutput({label, " busy after last word"}, 32'(bus.busy), 32'd0);
      checkOutput({label, " ready after last word"}, 32'(bus.in_ready), 32'd0);
    end else begin
      checkOutput({label, " still busy"}, 32'(bus.busy), 32'd1);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;

    vecs[0] = '{addr: 7'd5,   bank: 0,  expected: 16'd320,  name: "a5 b0"};
    vecs[1] = '{addr: 7'd5,   bank: 63, expected: 16'd383,  name: "a5 b63"};
    vecs[2] = '{addr: 7'd127, bank: 63, expected: 16'd8191, name: "a127 b63"};
    vecs[3] = '{addr: 7'd0,   bank: 0,  expected: 16'd0,    name: "a0 b0"};
    vecs[4] = '{addr: 7'd1,   bank: 36, expected: 16'd100,  name: "a1 b36"};
    vecs[5] = '{addr: 7'd64,  bank: 1,  expected: 16'd4097, name: "a64 b1"};
    vecs[6] = '{addr: 7'd100, bank: 20, expected: 16'd6420, name: "a100 b20"};
    vecs[7] = '{addr: 7'd127, bank: 0,  expected: 16'd8128, name: "a127 b0"};

    // Reset then idle with a valid word but no start.
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFFFF;
    bus.address  = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset loaded", 32'(bus.loaded), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idle ready", 32'(bus.in_ready), 32'd0);
    checkOutput("idle busy", 32'(bus.busy), 32'd0);
    checkOutput("idle loaded", 32'(bus.loaded), 32'd0);
    bus.in_valid = 1'b0;

    // Full-rate load of word i = i.
    loadStream(16'h0000, 1'b0, TOTAL, -1, "full");
    checkVectors();
    for (int k = 0; k < NUM; k++) applyStimulus(7'd5, WIDTH'(5 * NUM + k));
    #1;
    for (int k = 0; k < NUM; k++) checkRead(k, "a5 all banks");
    checkImage("full image");

    // Valid words while DONE must not be written.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFFFF;
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("done ready", 32'(bus.in_ready), 32'd0);
    checkImage("done no write");

    // Same stream with a one-cycle gap between words.
    loadStream(16'h0000, 1'b1, TOTAL, -1, "gapped");
    checkVectors();
    checkImage("gapped image");

    // Restart from DONE with a new pattern.
    loadStream(16'hA000, 1'b0, TOTAL, -1, "restart");
    applyStimulus(7'd127, 16'hA000 + 16'd8191);
    #1;
    checkRead(63, "restart a127 b63");
    checkImage("restart image");

    // A start pulse mid-load is ignored.
    loadStream(16'h5000, 1'b0, TOTAL, 100, "start ignored");
    applyStimulus(7'd1, 16'h5000 + 16'd100);
    #1;
    checkRead(36, "word100 a1 b36");
    checkImage("start ignored image");

    // Reset part way through a load; the outputs drop asynchronously.
    loadStream(16'hC000, 1'b0, 300, -1, "partial");
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset busy", 32'(bus.busy), 32'd0);
    checkOutput("async reset ready", 32'(bus.in_ready), 32'd0);
    checkOutput("async reset loaded", 32'(bus.loaded), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("after reset busy", 32'(bus.busy), 32'd0);
    checkOutput("after reset loaded", 32'(bus.loaded), 32'd0);
    applyStimulus(7'd4, 16'hC000 + 16'd299);
    #1;
    checkRead(43, "word299 a4 b43");
    checkImage("partial image");

    // Reload after the abandoned load starts again from bank 0, address 0.
    loadStream(16'h3000, 1'b0, TOTAL, -1, "reload");
    applyStimulus(7'd0, 16'h3000);
    #1;
    checkRead(0, "reload a0 b0");
    checkImage("reload image");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
